// File: rtl/fetch_unit_if.sv
// Bundle of the fetch unit's memory, decoder and redirect handshakes.
// The master modport is the fetch unit; the slave side is memory, decoder and branch logic.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [7:0]  opcode;
    logic [31:0] pc_out;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [15:0] fetch_count;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, opcode, pc_out, fetch_count,
        input  imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, opcode, pc_out, fetch_count,
        output imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch stage: request a word, hold it for the decoder,
// and follow redirects without ever abandoning a memory request that is still in flight.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input logic        clk,
    input logic        rst_n,
    fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DRAIN
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] drain_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH: begin
                if (bus.redirect) begin
                    state_next = bus.imem_ack ? FETCH : DRAIN;
                end else if (bus.imem_ack) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (bus.redirect || bus.instr_ready) begin
                    state_next = FETCH;
                end
            end
            DRAIN: begin
                if (bus.imem_ack) begin
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    // While draining, pc already points at the redirect target, so the stale address is replayed.
    always_comb begin
        bus.imem_req    = (state != HOLD);
        bus.imem_addr   = (state == DRAIN) ? drain_addr : pc;
        bus.instr_valid = (state == HOLD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc              <= RESET_PC;
            drain_addr      <= 32'h0000_0000;
            bus.instr       <= 32'h0000_0000;
            bus.pc_out      <= 32'h0000_0000;
            bus.fetch_count <= 16'h0000;
        end else begin
            if (bus.redirect) begin
                pc <= bus.redirect_pc;
            end
            case (state)
                FETCH: begin
                    if (bus.imem_ack && !bus.redirect) begin
                        bus.instr  <= bus.imem_rdata;
                        bus.pc_out <= pc;
                        pc         <= pc + PC_STEP;
                    end else if (!bus.imem_ack && bus.redirect) begin
                        drain_addr <= pc;
                    end
                end
                HOLD: begin
                    if (bus.instr_ready && !bus.redirect) begin
                        bus.fetch_count <= bus.fetch_count + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.opcode = bus.instr[31:24];

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter PC_STEP, default 4, the PC increment per delivered instruction.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port imem_req  output  1  instruction memory read request.
REQ-006 SHALL have port imem_addr  output  32  read address, valid while imem_req=1.
REQ-007 SHALL have port imem_ack  input  1  memory returns data this cycle; only meaningful while imem_req=1.
REQ-008 SHALL have port imem_rdata  input  32  instruction word, sampled when imem_req=1 and imem_ack=1.
REQ-009 SHALL have port instr_valid  output  1  instr/opcode/pc_out hold a deliverable instruction.
REQ-010 SHALL have port instr_ready  input  1  decoder accepts the instruction.
REQ-011 SHALL have port instr  output  32  held instruction word.
REQ-012 SHALL have port opcode  output  8  instr[31:24], the field feeding the control decoder input.
REQ-013 SHALL have port pc_out  output  32  address the held instruction was fetched from.
REQ-014 SHALL have port redirect  input  1  jump/taken-branch redirect request.
REQ-015 SHALL have port redirect_pc  input  32  new fetch address, sampled when redirect=1.
REQ-016 SHALL have port fetch_count  output  16  count of accepted instructions.

Function
REQ-017 SHALL implement states FETCH, HOLD, DRAIN, with a 32-bit register pc holding the next fetch address.
REQ-018 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc.
REQ-019 Once asserted, imem_req and imem_addr SHALL remain stable until the cycle imem_ack=1, including across redirect.
REQ-020 In FETCH with imem_ack=1 and redirect=0: instr<=imem_rdata, pc_out<=pc, pc<=pc+PC_STEP (mod 2^32), next state HOLD.
REQ-021 In HOLD, instr_valid SHALL be 1, imem_req SHALL be 0, and instr/opcode/pc_out SHALL remain stable.
REQ-022 In HOLD with instr_valid=1, instr_ready=1 and redirect=0: instruction accepted, fetch_count increments by 1, next state FETCH.
REQ-023 There SHALL be one cycle of imem_req=0 between an accept and the next request; the handshake latency is 1 cycle plus memory wait cycles.
REQ-024 In HOLD with instr_ready=0, the state SHALL remain HOLD indefinitely.
REQ-025 Redirect SHALL have priority over every other event, and pc SHALL be loaded with redirect_pc in all states.
REQ-026 Redirect in HOLD: instr_valid<=0, held instruction discarded even if instr_ready=1, fetch_count unchanged, next state FETCH.
REQ-027 Redirect in FETCH with imem_ack=1: returned data discarded, next state FETCH at redirect_pc.
REQ-028 Redirect in FETCH with imem_ack=0: next state DRAIN.
REQ-029 In DRAIN, the old request SHALL be held per REQ-019.
REQ-030 In DRAIN, imem_ack=1 SHALL discard the data and move to FETCH; a further redirect in DRAIN SHALL overwrite pc and stay in DRAIN unless ack arrives.
REQ-031 instr_valid SHALL be 1 only in HOLD and SHALL never be 1 in FETCH or DRAIN.
REQ-032 fetch_count SHALL wrap from 16'hFFFF to 16'h0000.
REQ-033 opcode SHALL be combinationally instr[31:24] at all times.

Reset
REQ-034 When rst_n=0 at a rising edge: state<=FETCH, pc<=RESET_PC, instr<=0, pc_out<=0, fetch_count<=0, instr_valid<=0.
REQ-035 In the first cycle after reset release, imem_req SHALL be 1 with imem_addr=RESET_PC.
REQ-036 Reset SHALL override redirect and any pending ack.
REQ-037 Reset during DRAIN or HOLD SHALL abandon the outstanding or held instruction with no fetch_count change beyond clearing to 0.

Verification
REQ-038 Scenario: reset release, ack in 1st cycle with rdata=32'h0100_0000, instr_ready=1 -> instr_valid=1 next cycle, opcode=8'h01, pc_out=0, then fetch_count=1 and imem_addr=4.
REQ-039 Scenario: memory ack delayed 3 cycles, decoder stalls 2 cycles -> imem_req/imem_addr held 4 cycles, instr stable through stall, exactly one increment.
REQ-040 Scenario: redirect to 32'h0000_0040 in HOLD with instr_ready=1 -> instr_valid drops, fetch_count unchanged, next imem_addr=32'h40.
REQ-041 Scenario: redirect to 32'h80 in FETCH with ack 2 cycles later, plus a second redirect to 32'hC0 in DRAIN -> the old address is held until ack, the data is dropped, and the next request goes to 32'hC0.
REQ-042 Scenario: pc=32'hFFFF_FFFC fetch accepted -> next imem_addr=0; fetch_count preset near 16'hFFFF wraps to 0.
REQ-043 Scenario: rst_n=0 asserted during DRAIN with redirect=1 -> after release, imem_addr=RESET_PC and instr_valid=0.
